// File: rtl/stopwatch_sec_counter.sv
// Seconds stopwatch: synchronised/debounced run-stop button, clear switch,
// 1 s prescaler and a 00..59 BCD seconds counter with second/minute pulses.
module stopwatch_sec_counter #(
  parameter int unsigned CLK_PER_SEC     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       switch,
  output logic [3:0] low_sec_dig,
  output logic [2:0] high_sec_dig,
  output logic       second,
  output logic       minute,
  output logic       running
);

  localparam int unsigned PS_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STOP,
    ST_RUN
  } state_e;

  state_e state_q, state_d;

  logic btn_meta_q, btn_sync_q;
  logic sw_meta_q, sw_sync_q;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            stable_q, stable_d;
  logic            stable_dly_q;
  logic            press_q, press_d;

  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0]      low_q, low_d;
  logic [2:0]      high_q, high_d;
  logic            sec_q, sec_d;
  logic            min_q, min_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_sync_q  <= 1'b0;
    end else begin
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= switch;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // The counter only advances while the synchronised level differs from the
  // accepted level; any return to the accepted level restarts the window.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (btn_sync_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      stable_d = btn_sync_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign press_d = stable_q & ~stable_dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt_q     <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (press_q) begin
      state_d = (state_q == ST_STOP) ? ST_RUN : ST_STOP;
    end
  end

  always_comb begin
    running = (state_q == ST_RUN);
  end

  // Clear is only honoured while stopped; a press in the same cycle still
  // moves the FSM to RUN, so counting restarts from 00.
  always_comb begin
    ps_d   = ps_q;
    low_d  = low_q;
    high_d = high_q;
    sec_d  = 1'b0;
    min_d  = 1'b0;
    if (state_q == ST_RUN) begin
      if (ps_q == PS_LAST) begin
        ps_d  = '0;
        sec_d = 1'b1;
        if (low_q == 4'd9) begin
          low_d = '0;
          if (high_q == 3'd5) begin
            high_d = '0;
            min_d  = 1'b1;
          end else begin
            high_d = high_q + 3'd1;
          end
        end else begin
          low_d = low_q + 4'd1;
        end
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end else if (sw_sync_q) begin
      ps_d   = '0;
      low_d  = '0;
      high_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q   <= '0;
      low_q  <= '0;
      high_q <= '0;
      sec_q  <= 1'b0;
      min_q  <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      low_q  <= low_d;
      high_q <= high_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
    end
  end

  assign low_sec_dig  = low_q;
  assign high_sec_dig = high_q;
  assign second       = sec_q;
  assign minute       = min_q;

endmodule

// File: tb/tb_stopwatch_sec_counter.sv
// Bench for stopwatch_sec_counter: elapsed seconds are modelled as an integer
// (digits = secs%10, secs/10) and checked on every sampled cycle.
module tb_stopwatch_sec_counter;

  localparam int unsigned CPS = 4;
  localparam int unsigned DB  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       switch = 1'b0;
  logic [3:0] low_sec_dig;
  logic [2:0] high_sec_dig;
  logic       second;
  logic       minute;
  logic       running;

  stopwatch_sec_counter #(
    .CLK_PER_SEC    (CPS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button      (button),
    .switch      (switch),
    .low_sec_dig (low_sec_dig),
    .high_sec_dig(high_sec_dig),
    .second      (second),
    .minute      (minute),
    .running     (running)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int model_secs = 0;
  int pulses = 0;
  int run_cnt = 0;
  bit model_run = 1'b0;
  bit chk_digits = 1'b1;
  bit prev_running = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge and update the seconds model.
  task automatic cyc();
    @(negedge clock);
    if (second === 1'b1) begin
      chk("second_only_when_running", prev_running, 1);
      chk("second_spacing", run_cnt, CPS);
      run_cnt = 0;
      pulses++;
      model_secs = (model_secs + 1) % 60;
      chk("low_on_tick", low_sec_dig, model_secs % 10);
      chk("high_on_tick", high_sec_dig, model_secs / 10);
      chk("minute_on_tick", minute, (model_secs == 0));
    end else begin
      chk("minute_without_second", minute, 0);
      if (chk_digits) begin
        chk("low_hold", low_sec_dig, model_secs % 10);
        chk("high_hold", high_sec_dig, model_secs / 10);
      end
    end
    if (running === 1'b1) run_cnt++;
    prev_running = running;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_secs = 0;
    run_cnt = 0;
    model_run = 1'b0;
    cyc();
    chk("rst_low", low_sec_dig, 0);
    chk("rst_high", high_sec_dig, 0);
    chk("rst_second", second, 0);
    chk("rst_minute", minute, 0);
    chk("rst_running", running, 0);
    for (int i = 1; i < n; i++) cyc();
    reset = 1'b0;
  endtask

  task automatic press(input int hold);
    int lat = 0;
    bit seen = 1'b0;
    bit want;
    want = !model_run;
    button = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      cyc();
      if (!seen && running === want) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk("press_toggled", seen, 1);
    chk("press_latency_6_to_8", (lat >= 6 && lat <= 8), 1);
    button = 1'b0;
    model_run = want;
    for (int i = 0; i < 2 + DB + 4; i++) begin
      cyc();
      chk("release_no_toggle", running, model_run);
    end
  endtask

  task automatic run_until(input int target);
    int budget;
    budget = (target - pulses) * CPS + 20;
    while (pulses < target && budget > 0) begin
      cyc();
      budget--;
    end
    chk("pulse_count_reached", pulses, target);
  endtask

  task automatic bounce();
    for (int i = 0; i < 10; i++) begin
      button = (i % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      chk("bounce_running", running, model_run);
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bounce_settle_running", running, model_run);
    end
  endtask

  initial begin
    int p0;
    int budget;

    // Reset and idle
    do_reset(3);
    for (int i = 0; i < 100; i++) cyc();
    chk("idle_running", running, 0);
    chk("idle_pulses", pulses, 0);

    // Clean press, count to ten and a full minute
    press(20);
    chk("running_after_press", running, 1);
    run_until(10);
    chk("ten_high", high_sec_dig, 1);
    chk("ten_low", low_sec_dig, 0);
    run_until(60);
    chk("wrap_second", second, 1);
    chk("wrap_minute", minute, 1);
    chk("wrap_low", low_sec_dig, 0);
    chk("wrap_high", high_sec_dig, 0);
    cyc();
    chk("minute_one_cycle", minute, 0);

    // Bounce while running
    bounce();

    // Random pause/resume with glitches while stopped
    for (int k = 0; k < 4; k++) begin
      run_until(pulses + int'($urandom_range(3, 20)));
      press(int'($urandom_range(10, 25)));
      chk("paused", running, 0);
      p0 = pulses;
      for (int i = 0; i < int'($urandom_range(5, 40)); i++) cyc();
      bounce();
      chk("no_pulse_when_paused", pulses, p0);
      press(int'($urandom_range(10, 25)));
    end

    // Stop, clear, then switch held while running
    run_until(pulses + 7);
    press(12);
    switch = 1'b1;
    chk_digits = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("clear_no_second", second, 0);
    end
    chk("clear_low", low_sec_dig, 0);
    chk("clear_high", high_sec_dig, 0);
    model_secs = 0;
    run_cnt = 0;
    switch = 1'b0;
    chk_digits = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    press(15);
    switch = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 15; i++) cyc();
    switch = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("switch_ignored_in_run", (pulses - p0 >= 4), 1);

    // Reset at 00:42
    budget = 61 * CPS + 20;
    while (!(model_secs == 42 && second === 1'b1) && budget > 0) begin
      cyc();
      budget--;
    end
    chk("reached_42", model_secs, 42);
    do_reset(3);
    for (int i = 0; i < 30; i++) cyc();
    chk("stays_stopped_after_reset", running, 0);
    chk("digits_zero_after_reset", {high_sec_dig, low_sec_dig}, 0);
    press(15);
    run_until(pulses + 3);
    chk("resumed_low", low_sec_dig, model_secs % 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
